// File: rtl/xc_ssm4_seq_if.sv
// Operand/result handshake bundle for the SM4 execute unit.
//   master (issue/writeback side): drives operands, in_valid, out_ready
//   slave  (xc_ssm4_seq):          drives in_ready, out_valid, result
interface xc_ssm4_seq_if;
  logic        in_valid;
  logic        in_ready;
  logic        op_ed;
  logic        op_ks;
  logic [31:0] rs1;
  logic [31:0] rs2;
  logic [1:0]  bs;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;

  modport master (
    output in_valid, op_ed, op_ks, rs1, rs2, bs, out_ready,
    input  in_ready, out_valid, result
  );

  modport slave (
    input  in_valid, op_ed, op_ks, rs1, rs2, bs, out_ready,
    output in_ready, out_valid, result
  );
endinterface

// File: rtl/xc_ssm4_seq.sv
// Multi-cycle execute unit for scalar SM4 ssm4.ed / ssm4.ks.
// One op per handshake; a single byte S-box feeds the linear transform,
// rotation by 8*bs and XOR into rs1. Result is held until writeback takes it.
//   g_clk     core clock
//   g_resetn  asynchronous active-low reset
//   flush     abort any in-flight op, back to IDLE next cycle
//   io        xc_ssm4_seq_if.slave: operands/valid/ready/result
// Build option: XC_SSM4_SBOX_REG_EN splits the S-box into two registered
// halves (extra SBOX2 state, latency 4 instead of 3).
module xc_ssm4_seq (
  input logic          g_clk,
  input logic          g_resetn,
  input logic          flush,
  xc_ssm4_seq_if.slave io
);

  typedef enum logic [2:0] {IDLE, SBOX, SBOX2, MIX, DONE} state_t;

  localparam logic [7:0] SBOX_TBL [256] = '{
    8'hd6,8'h90,8'he9,8'hfe,8'hcc,8'he1,8'h3d,8'hb7,8'h16,8'hb6,8'h14,8'hc2,8'h28,8'hfb,8'h2c,8'h05,
    8'h2b,8'h67,8'h9a,8'h76,8'h2a,8'hbe,8'h04,8'hc3,8'haa,8'h44,8'h13,8'h26,8'h49,8'h86,8'h06,8'h99,
    8'h9c,8'h42,8'h50,8'hf4,8'h91,8'hef,8'h98,8'h7a,8'h33,8'h54,8'h0b,8'h43,8'hed,8'hcf,8'hac,8'h62,
    8'he4,8'hb3,8'h1c,8'ha9,8'hc9,8'h08,8'he8,8'h95,8'h80,8'hdf,8'h94,8'hfa,8'h75,8'h8f,8'h3f,8'ha6,
    8'h47,8'h07,8'ha7,8'hfc,8'hf3,8'h73,8'h17,8'hba,8'h83,8'h59,8'h3c,8'h19,8'he6,8'h85,8'h4f,8'ha8,
    8'h68,8'h6b,8'h81,8'hb2,8'h71,8'h64,8'hda,8'h8b,8'hf8,8'heb,8'h0f,8'h4b,8'h70,8'h56,8'h9d,8'h35,
    8'h1e,8'h24,8'h0e,8'h5e,8'h63,8'h58,8'hd1,8'ha2,8'h25,8'h22,8'h7c,8'h3b,8'h01,8'h21,8'h78,8'h87,
    8'hd4,8'h00,8'h46,8'h57,8'h9f,8'hd3,8'h27,8'h52,8'h4c,8'h36,8'h02,8'he7,8'ha0,8'hc4,8'hc8,8'h9e,
    8'hea,8'hbf,8'h8a,8'hd2,8'h40,8'hc7,8'h38,8'hb5,8'ha3,8'hf7,8'hf2,8'hce,8'hf9,8'h61,8'h15,8'ha1,
    8'he0,8'hae,8'h5d,8'ha4,8'h9b,8'h34,8'h1a,8'h55,8'had,8'h93,8'h32,8'h30,8'hf5,8'h8c,8'hb1,8'he3,
    8'h1d,8'hf6,8'he2,8'h2e,8'h82,8'h66,8'hca,8'h60,8'hc0,8'h29,8'h23,8'hab,8'h0d,8'h53,8'h4e,8'h6f,
    8'hd5,8'hdb,8'h37,8'h45,8'hde,8'hfd,8'h8e,8'h2f,8'h03,8'hff,8'h6a,8'h72,8'h6d,8'h6c,8'h5b,8'h51,
    8'h8d,8'h1b,8'haf,8'h92,8'hbb,8'hdd,8'hbc,8'h7f,8'h11,8'hd9,8'h5c,8'h41,8'h1f,8'h10,8'h5a,8'hd8,
    8'h0a,8'hc1,8'h31,8'h88,8'ha5,8'hcd,8'h7b,8'hbd,8'h2d,8'h74,8'hd0,8'h12,8'hb8,8'he5,8'hb4,8'hb0,
    8'h89,8'h69,8'h97,8'h4a,8'h0c,8'h96,8'h77,8'h7e,8'h65,8'hb9,8'hf1,8'h09,8'hc5,8'h6e,8'hc6,8'h84,
    8'h18,8'hf0,8'h7d,8'hec,8'h3a,8'hdc,8'h4d,8'h20,8'h79,8'hee,8'h5f,8'h3e,8'hd7,8'hcb,8'h39,8'h48
  };

  state_t      state, nxt;
  logic [31:0] rs1_q, result_q;
  logic [7:0]  byte_q, x_q;
  logic [1:0]  bs_q;
  logic        ks_q;
  logic        accept;
  logic [7:0]  byte_sel;
  logic [31:0] xw, y, y_rol;

  assign accept       = (state == IDLE) && io.in_valid && !flush;
  assign io.in_ready  = (state == IDLE);
  assign io.out_valid = (state == DONE);
  assign io.result    = result_q;

  // FSM next state; flush overrides every other transition
  always_comb begin
    nxt = state;
    case (state)
      IDLE:  if (io.in_valid) nxt = SBOX;
`ifdef XC_SSM4_SBOX_REG_EN
      SBOX:  nxt = SBOX2;
      SBOX2: nxt = MIX;
`else
      SBOX:  nxt = MIX;
`endif
      MIX:   nxt = DONE;
      DONE:  if (io.out_ready) nxt = IDLE;
      default: nxt = IDLE;
    endcase
    if (flush) nxt = IDLE;
  end

  always_ff @(posedge g_clk or negedge g_resetn) begin
    if (!g_resetn) state <= IDLE;
    else           state <= nxt;
  end

  always_comb begin
    byte_sel = io.rs2[7:0];
    case (io.bs)
      2'd1: byte_sel = io.rs2[15:8];
      2'd2: byte_sel = io.rs2[23:16];
      2'd3: byte_sel = io.rs2[31:24];
      default: byte_sel = io.rs2[7:0];
    endcase
  end

  // Linear transform on the zero-extended S-box output, then ROL32 by 8*bs
  always_comb begin
    xw = {24'h0, x_q};
    if (ks_q)
      y = xw ^ ((xw & 32'h07) << 29) ^ ((xw & 32'hFE) << 7)
             ^ ((xw & 32'h01) << 23) ^ ((xw & 32'hF8) << 13);
    else
      y = xw ^ (xw << 8) ^ (xw << 2) ^ (xw << 18)
             ^ ((xw & 32'h3F) << 26) ^ ((xw & 32'hC0) << 10);
    case (bs_q)
      2'd1: y_rol = {y[23:0], y[31:24]};
      2'd2: y_rol = {y[15:0], y[31:16]};
      2'd3: y_rol = {y[7:0],  y[31:8]};
      default: y_rol = y;
    endcase
  end

`ifdef XC_SSM4_SBOX_REG_EN
  // Both candidate entries for the low 7 index bits are registered in SBOX;
  // SBOX2 picks one with the top index bit, keeping each stage shallow.
  logic [7:0] lo_q, hi_q;
  always_ff @(posedge g_clk or negedge g_resetn) begin
    if (!g_resetn) begin
      lo_q <= '0;
      hi_q <= '0;
    end else if (state == SBOX) begin
      lo_q <= SBOX_TBL[{1'b0, byte_q[6:0]}];
      hi_q <= SBOX_TBL[{1'b1, byte_q[6:0]}];
    end
  end
`endif

  always_ff @(posedge g_clk or negedge g_resetn) begin
    if (!g_resetn) begin
      rs1_q    <= '0;
      byte_q   <= '0;
      bs_q     <= '0;
      ks_q     <= 1'b0;
      x_q      <= '0;
      result_q <= '0;
    end else begin
      if (accept) begin
        rs1_q  <= io.rs1;
        byte_q <= byte_sel;
        bs_q   <= io.bs;
        // ed wins when both are set; neither set also decodes as ed
        ks_q   <= io.op_ks && !io.op_ed;
      end
`ifdef XC_SSM4_SBOX_REG_EN
      if (state == SBOX2) x_q <= byte_q[7] ? hi_q : lo_q;
`else
      if (state == SBOX)  x_q <= SBOX_TBL[byte_q];
`endif
      if (state == MIX && !flush) result_q <= rs1_q ^ y_rol;
    end
  end

endmodule

// File: tb/tb_xc_ssm4_seq.sv
// Directed self-checking bench for xc_ssm4_seq: reset state, ed/ks vectors,
// byte-select sweep, latency, result hold, flush and mid-op reset.
module tb_xc_ssm4_seq;

`ifdef XC_SSM4_SBOX_REG_EN
  localparam int LAT = 4;
`else
  localparam int LAT = 3;
`endif

  logic g_clk = 1'b0;
  logic g_resetn = 1'b0;
  logic flush = 1'b0;
  int   checks = 0;
  int   errors = 0;

  xc_ssm4_seq_if io();

  xc_ssm4_seq dut (
    .g_clk    (g_clk),
    .g_resetn (g_resetn),
    .flush    (flush),
    .io       (io)
  );

  always #5 g_clk = ~g_clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  task automatic issue(input logic ed, input logic ks, input logic [31:0] a,
                       input logic [31:0] b, input logic [1:0] s);
    @(negedge g_clk);
    chk("in_ready_idle", {31'h0, io.in_ready}, 32'h1);
    io.in_valid = 1'b1; io.op_ed = ed; io.op_ks = ks;
    io.rs1 = a; io.rs2 = b; io.bs = s; io.out_ready = 1'b0;
    @(posedge g_clk);
    #1 io.in_valid = 1'b0;
  endtask

  // Issue, measure latency to out_valid, check result, then retire it
  task automatic run_op(input string tag, input logic ed, input logic ks,
                        input logic [31:0] a, input logic [31:0] b,
                        input logic [1:0] s, input logic [31:0] exp);
    int n;
    issue(ed, ks, a, b, s);
    n = 0;
    while (n <= 10) begin
      @(negedge g_clk);
      n++;
      if (io.out_valid) break;
    end
    chk({tag, "_lat"}, 32'(n), 32'(LAT));
    chk(tag, io.result, exp);
    chk({tag, "_busy"}, {31'h0, io.in_ready}, 32'h0);
    io.out_ready = 1'b1;
    @(posedge g_clk);
    #1 io.out_ready = 1'b0;
    @(negedge g_clk);
    chk({tag, "_ret"}, {30'h0, io.out_valid, io.in_ready}, 32'h1);
  endtask

  initial begin
    int pulses;
    io.in_valid = 1'b0; io.op_ed = 1'b0; io.op_ks = 1'b0;
    io.rs1 = '0; io.rs2 = '0; io.bs = '0; io.out_ready = 1'b0;
    #12;
    chk("rst_out_valid", {31'h0, io.out_valid}, 32'h0);
    chk("rst_result", io.result, 32'h0);
    @(negedge g_clk) g_resetn = 1'b1;
    @(negedge g_clk);
    chk("rst_in_ready", {31'h0, io.in_ready}, 32'h1);

    // Sweep with sbox(0)=D6
    run_op("ed_bs0", 1, 0, 32'h0, 32'h0, 2'd0, 32'h5B5BD58E);
    run_op("ed_rs1x", 1, 0, 32'h5B5BD58E, 32'h0, 2'd0, 32'h00000000);
    run_op("ed_bs1", 1, 0, 32'h0, 32'h0, 2'd1, 32'h5BD58E5B);
    run_op("ed_bs2", 1, 0, 32'h0, 32'h0, 2'd2, 32'hD58E5B5B);
    run_op("ed_bs3", 1, 0, 32'h0, 32'h0, 2'd3, 32'h8E5B5BD5);
    run_op("ks_zero", 0, 1, 32'h0, 32'h0, 2'd0, 32'hC01A6BD6);
    run_op("both_ed", 1, 1, 32'h0, 32'h0, 2'd0, 32'h5B5BD58E);
    run_op("none_ed", 0, 0, 32'h0, 32'h0, 2'd0, 32'h5B5BD58E);
    // sbox(01)=90, sbox(80)=EA, sbox(FF)=48
    run_op("ed_b01", 1, 0, 32'hFFFFFFFF, 32'h00000100, 2'd1, 32'hBD6D2FBD);
    run_op("ks_b01", 0, 1, 32'h12345678, 32'hAABBCC01, 2'd0, 32'h12261EE8);
    run_op("ed_b80", 1, 0, 32'h0, 32'h00800000, 2'd2, 32'hE942ABAB);
    run_op("ks_bff", 0, 1, 32'h0, 32'hFF000000, 2'd3, 32'h48000924);

    // Hold in DONE with out_ready low
    issue(1, 0, 32'h0, 32'h0, 2'd1);
    repeat (LAT) @(negedge g_clk);
    for (int i = 0; i < 5; i++) begin
      chk("hold_res", io.result, 32'h5BD58E5B);
      chk("hold_vr", {30'h0, io.out_valid, io.in_ready}, 32'h2);
      @(negedge g_clk);
    end
    io.out_ready = 1'b1;
    @(posedge g_clk);
    #1 io.out_ready = 1'b0;

    // Flush while in SBOX
    issue(1, 0, 32'h0, 32'h0, 2'd0);
    flush = 1'b1;
    @(posedge g_clk);
    #1 flush = 1'b0;
    @(negedge g_clk);
    chk("flush_rdy", {31'h0, io.in_ready}, 32'h1);
    pulses = 0;
    for (int i = 0; i < 6; i++) begin
      if (io.out_valid) pulses++;
      @(negedge g_clk);
    end
    chk("flush_nopulse", 32'(pulses), 32'h0);

    // flush beats in_valid in IDLE
    io.in_valid = 1'b1; flush = 1'b1;
    @(posedge g_clk);
    #1 begin io.in_valid = 1'b0; flush = 1'b0; end
    pulses = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge g_clk);
      if (io.out_valid || !io.in_ready) pulses++;
    end
    chk("flush_idle", 32'(pulses), 32'h0);

    // Complete one op so result is nonzero, then reset mid-MIX
    run_op("pre_rst", 1, 0, 32'h0, 32'h0, 2'd0, 32'h5B5BD58E);
    issue(0, 1, 32'h0, 32'h0, 2'd0);
    repeat (LAT - 2) @(posedge g_clk);
    #2 g_resetn = 1'b0;
    #1;
    chk("mid_rst_ov", {31'h0, io.out_valid}, 32'h0);
    chk("mid_rst_res", io.result, 32'h0);
    @(negedge g_clk) g_resetn = 1'b1;
    run_op("post_rst", 0, 1, 32'h12345678, 32'hAABBCC01, 2'd0, 32'h12261EE8);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
